// File: rtl/rab_chk_pkg.sv
// rtl/rab_chk_pkg.sv - shared types and address helpers for the RAB translation checker
//
// Purpose: entry flag record, per-read result code and page arithmetic helpers
// used by rab_xlat_checker. Width-dependent entry payload (id, addr, page,
// beat, age) lives in per-field arrays in the top, because those widths are
// parameters of the checker and not of this package.
package rab_chk_pkg;

  typedef enum logic [1:0] {HIT, MISS, SKIP, ERR} result_e;

  // Per-entry status flags. oor marks an address outside the tracked page
  // range: it is always an expected miss and bitmap events cannot dirty it.
  typedef struct packed {
    logic valid;
    logic exp_hit;
    logic oor;
    logic dirty;
    logic skip;
    logic err;
  } entry_t;

  // Page index of an address: page_w bits starting at page_bits.
  function automatic logic [31:0] page_of(input logic [63:0] addr,
                                          input int page_bits,
                                          input int page_w);
    logic [63:0] p;
    p = (addr >> page_bits) & ((64'd1 << page_w) - 64'd1);
    return p[31:0];
  endfunction

  // True when the last byte of the burst lies in a different page than the first.
  function automatic logic crosses_page(input logic [63:0] addr,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size,
                                        input int          page_bits);
    logic [63:0] last;
    last = addr + (({56'd0, len} + 64'd1) << size) - 64'd1;
    return (last >> page_bits) != (addr >> page_bits);
  endfunction

endpackage

// File: rtl/rab_chk_oldest_match.sv
// rtl/rab_chk_oldest_match.sv - wrap-around priority search for a matching table slot
//
// Purpose: scans N slots starting at 'start' and wrapping, returning the first
// slot whose valid bit is set and whose id equals 'key'.
// Ports:
//   valid [N]     candidate slots
//   ids   [N*IW]  flattened slot ids, slot i at ids[i*IW +: IW]
//   start         first slot examined
//   key           id to match
//   found / idx   match flag and slot index
module rab_chk_oldest_match #(
  parameter int N  = 8,
  parameter int IW = 10,
  parameter int XW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid,
  input  logic [N*IW-1:0] ids,
  input  logic [XW-1:0]   start,
  input  logic [IW-1:0]   key,
  output logic            found,
  output logic [XW-1:0]   idx
);

  always_comb begin
    int p;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int i = 0; i < N; i++) begin
      p = (int'(start) + i) % N;
      if (!found && valid[p] && (ids[p*IW +: IW] == key)) begin
        found = 1'b1;
        idx   = XW'(p);
      end
    end
  end

endmodule

// File: rtl/rab_xlat_checker.sv
// rtl/rab_xlat_checker.sv - passive scoreboard checking RAB read translations
//
// Purpose: watches AR/R handshakes and page-state events, keeps a shadow page
// valid bitmap and a table of in-flight reads, and classifies every completed
// read as hit, miss, skip or error.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   ar_*_i                          monitored read address channel
//   r_*_i                           monitored read data channel
//   init_all_i, inval_*, ins_*      page-state events
//   page_valid_o                    shadow bitmap
//   err_o, err_sticky_o, overflow_o error pulse and sticky flags
//   hit/miss/skip/err_cnt_o         saturating result counters
//   outst_o                         table entries in use
module rab_xlat_checker
  import rab_chk_pkg::*;
#(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             IW        = 10,
  parameter int             N_PAGES   = 64,
  parameter int             PAGE_BITS = 12,
  parameter int             MAX_OUTST = 8,
  parameter logic [DW-1:0]  PA_OFFSET = DW'(32'hff000000),
  parameter int             CW        = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ar_valid_i,
  input  logic                           ar_ready_i,
  input  logic [AW-1:0]                  ar_addr_i,
  input  logic [IW-1:0]                  ar_id_i,
  input  logic [7:0]                     ar_len_i,
  input  logic [2:0]                     ar_size_i,
  input  logic                           r_valid_i,
  input  logic                           r_ready_i,
  input  logic [IW-1:0]                  r_id_i,
  input  logic [1:0]                     r_resp_i,
  input  logic [DW-1:0]                  r_data_i,
  input  logic                           r_last_i,
  input  logic                           init_all_i,
  input  logic                           inval_valid_i,
  input  logic [$clog2(N_PAGES)-1:0]     inval_page_i,
  input  logic                           ins_valid_i,
  input  logic [$clog2(N_PAGES)-1:0]     ins_page_i,
  output logic [N_PAGES-1:0]             page_valid_o,
  output logic                           err_o,
  output logic                           err_sticky_o,
  output logic                           overflow_o,
  output logic [CW-1:0]                  hit_cnt_o,
  output logic [CW-1:0]                  miss_cnt_o,
  output logic [CW-1:0]                  skip_cnt_o,
  output logic [CW-1:0]                  err_cnt_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_o
);

  localparam int PW = $clog2(N_PAGES);
  localparam int XW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] inc);
    logic [CW:0] s;
    s = {1'b0, a} + {{(CW-1){1'b0}}, inc};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  entry_t        ent   [MAX_OUTST];
  entry_t        ent_n [MAX_OUTST];
  logic [IW-1:0] e_id   [MAX_OUTST];
  logic [AW-1:0] e_addr [MAX_OUTST];
  logic [PW-1:0] e_page [MAX_OUTST];
  logic [2:0]    e_size [MAX_OUTST];
  logic [7:0]    e_beat [MAX_OUTST];
  // Number of older in-flight entries with the same id; only age 0 may match R.
  logic [XW-1:0] e_age  [MAX_OUTST];
  logic [XW-1:0] alloc_ptr;

  logic                 ar_fire, r_fire, full, do_alloc, ovf;
  logic [PW-1:0]        ar_page;
  logic                 ar_oor, ar_exp_hit, ar_skip;
  logic [N_PAGES-1:0]   inval_mask, ins_mask, touch, pv_next;
  logic [MAX_OUTST-1:0] head_ok, free_v;
  logic [MAX_OUTST*IW-1:0] ids_flat;
  logic [MAX_OUTST*IW-1:0] zero_ids;
  logic                 m_found, f_found;
  logic [XW-1:0]        m_idx, f_idx;
  logic [AW-1:0]        beat_addr;
  logic [DW-1:0]        exp_data;
  logic                 beat_err, retire, unexp;
  result_e              res;
  logic [XW-1:0]        alloc_age;
  logic [1:0]           hit_inc, miss_inc, skip_inc, err_inc;

  assign ar_fire  = ar_valid_i & ar_ready_i;
  assign r_fire   = r_valid_i & r_ready_i;
  assign full     = (outst_o == OW'(MAX_OUTST));
  assign do_alloc = ar_fire & ~full;
  assign ovf      = ar_fire & full;
  assign ar_page  = PW'(page_of(64'(ar_addr_i), PAGE_BITS, PW));
  assign ar_oor   = (AW > PAGE_BITS + PW) ? ((ar_addr_i >> (PAGE_BITS + PW)) != '0) : 1'b0;
  assign ar_exp_hit = page_valid_o[ar_page] & ~ar_oor;
  assign ar_skip  = crosses_page(64'(ar_addr_i), ar_len_i, ar_size_i, PAGE_BITS);
  assign zero_ids = '0;

  always_comb begin
    inval_mask = '0;
    ins_mask   = '0;
    if (inval_valid_i) inval_mask[inval_page_i] = 1'b1;
    if (ins_valid_i)   ins_mask[ins_page_i]     = 1'b1;
    touch   = {N_PAGES{init_all_i}} | inval_mask | ins_mask;
    // Insert is applied after invalidate so a same-page pair leaves the page valid.
    pv_next = init_all_i ? {N_PAGES{1'b1}} : ((page_valid_o & ~inval_mask) | ins_mask);
  end

  always_comb begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      head_ok[i]            = ent[i].valid && (e_age[i] == '0);
      free_v[i]             = ~ent[i].valid;
      ids_flat[i*IW +: IW]  = e_id[i];
    end
  end

  rab_chk_oldest_match #(.N(MAX_OUTST), .IW(IW), .XW(XW)) u_match (
    .valid (head_ok),
    .ids   (ids_flat),
    .start (alloc_ptr),
    .key   (r_id_i),
    .found (m_found),
    .idx   (m_idx)
  );

  rab_chk_oldest_match #(.N(MAX_OUTST), .IW(IW), .XW(XW)) u_free (
    .valid (free_v),
    .ids   (zero_ids),
    .start (alloc_ptr),
    .key   ({IW{1'b0}}),
    .found (f_found),
    .idx   (f_idx)
  );

  // Beat check and retirement classification for the matched entry.
  always_comb begin
    beat_addr = e_addr[m_idx] + (AW'(e_beat[m_idx]) << e_size[m_idx]);
    exp_data  = PA_OFFSET + DW'(beat_addr);
    if (ent[m_idx].exp_hit) beat_err = (r_resp_i != 2'b00) || (r_data_i != exp_data);
    else                    beat_err = (r_resp_i == 2'b00);
    retire = r_fire & m_found & r_last_i;
    unexp  = r_fire & ~m_found;
    if (ent[m_idx].dirty || ent[m_idx].skip)  res = SKIP;
    else if (ent[m_idx].err || beat_err)      res = ERR;
    else if (ent[m_idx].exp_hit)              res = HIT;
    else                                      res = MISS;
    hit_inc  = {1'b0, retire && (res == HIT)};
    miss_inc = {1'b0, retire && (res == MISS)};
    skip_inc = {1'b0, retire && (res == SKIP)} + {1'b0, ovf};
    err_inc  = {1'b0, (retire && (res == ERR)) || unexp};
  end

  // A slot retiring this cycle is no longer older than the new entry.
  always_comb begin
    alloc_age = '0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (ent[i].valid && (e_id[i] == ar_id_i) && !(retire && (m_idx == XW'(i))))
        alloc_age = alloc_age + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      ent_n[i] = ent[i];
      if (ent[i].valid && touch[e_page[i]] && !ent[i].oor) ent_n[i].dirty = 1'b1;
      if (r_fire && m_found && (m_idx == XW'(i))) begin
        ent_n[i].err = ent[i].err | beat_err;
        if (r_last_i) ent_n[i].valid = 1'b0;
      end
      if (do_alloc && f_found && (f_idx == XW'(i))) begin
        ent_n[i].valid   = 1'b1;
        ent_n[i].exp_hit = ar_exp_hit;
        ent_n[i].oor     = ar_oor;
        ent_n[i].dirty   = touch[ar_page] & ~ar_oor;
        ent_n[i].skip    = ar_skip;
        ent_n[i].err     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      page_valid_o <= '0;
      alloc_ptr    <= '0;
      outst_o      <= '0;
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
      overflow_o   <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
      skip_cnt_o   <= '0;
      err_cnt_o    <= '0;
      for (int i = 0; i < MAX_OUTST; i++) ent[i] <= '0;
    end else begin
      page_valid_o <= pv_next;
      for (int i = 0; i < MAX_OUTST; i++) ent[i] <= ent_n[i];
      if (do_alloc)
        alloc_ptr <= (f_idx == XW'(MAX_OUTST - 1)) ? '0 : f_idx + 1'b1;
      outst_o      <= outst_o + OW'(do_alloc) - OW'(retire);
      err_o        <= err_inc[0];
      err_sticky_o <= err_sticky_o | ovf | err_inc[0];
      overflow_o   <= overflow_o | ovf;
      hit_cnt_o    <= sat_add(hit_cnt_o, hit_inc);
      miss_cnt_o   <= sat_add(miss_cnt_o, miss_inc);
      skip_cnt_o   <= sat_add(skip_cnt_o, skip_inc);
      err_cnt_o    <= sat_add(err_cnt_o, err_inc);
    end
  end

  // Payload is only meaningful while the slot's valid flag is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (do_alloc && f_found && (f_idx == XW'(i))) begin
        e_id[i]   <= ar_id_i;
        e_addr[i] <= ar_addr_i;
        e_page[i] <= ar_page;
        e_size[i] <= ar_size_i;
        e_beat[i] <= 8'd0;
        e_age[i]  <= alloc_age;
      end else if (ent[i].valid) begin
        if (r_fire && m_found && (m_idx == XW'(i))) e_beat[i] <= e_beat[i] + 8'd1;
        if (retire && (m_idx != XW'(i)) && (e_id[i] == r_id_i) && (e_age[i] != '0))
          e_age[i] <= e_age[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rab_xlat_checker.sv
// tb/tb_rab_xlat_checker.sv - scoreboard bench for rab_xlat_checker
module tb_rab_xlat_checker;
  import rab_chk_pkg::*;

  localparam int AW = 32, DW = 32, IW = 10, N_PAGES = 64, PAGE_BITS = 12;
  localparam int MAX_OUTST = 8, CW = 32;

  logic clk = 1'b0, rst_i = 1'b1;
  logic ar_valid_i = 0, ar_ready_i = 0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [IW-1:0] ar_id_i = '0;
  logic [7:0] ar_len_i = '0;
  logic [2:0] ar_size_i = '0;
  logic r_valid_i = 0, r_ready_i = 0, r_last_i = 0;
  logic [IW-1:0] r_id_i = '0;
  logic [1:0] r_resp_i = '0;
  logic [DW-1:0] r_data_i = '0;
  logic init_all_i = 0, inval_valid_i = 0, ins_valid_i = 0;
  logic [5:0] inval_page_i = '0, ins_page_i = '0;
  logic [N_PAGES-1:0] page_valid_o;
  logic err_o, err_sticky_o, overflow_o;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o, skip_cnt_o, err_cnt_o;
  logic [3:0] outst_o;

  always #5 clk = ~clk;

  rab_xlat_checker #(.AW(AW), .DW(DW), .IW(IW), .N_PAGES(N_PAGES), .PAGE_BITS(PAGE_BITS),
                     .MAX_OUTST(MAX_OUTST), .PA_OFFSET(32'hff000000), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_id_i(r_id_i), .r_resp_i(r_resp_i),
    .r_data_i(r_data_i), .r_last_i(r_last_i),
    .init_all_i(init_all_i), .inval_valid_i(inval_valid_i), .inval_page_i(inval_page_i),
    .ins_valid_i(ins_valid_i), .ins_page_i(ins_page_i),
    .page_valid_o(page_valid_o), .err_o(err_o), .err_sticky_o(err_sticky_o),
    .overflow_o(overflow_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o),
    .skip_cnt_o(skip_cnt_o), .err_cnt_o(err_cnt_o), .outst_o(outst_o)
  );

  typedef struct {
    result_e kind;
    logic    erro;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input result_e k, input logic e);
    exp_t x;
    x.kind = k;
    x.erro = e;
    expq.push_back(x);
  endtask

  task automatic mon_cnt(input string nm, input logic [CW-1:0] cur, input logic [CW-1:0] prev,
                         input result_e kind);
    exp_t e;
    if (cur != prev) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_%s: actual=%0d required=%0d", nm, cur, prev);
      end else begin
        e = expq.pop_front();
        chk({"kind_", nm}, 64'(kind), 64'(e.kind));
        chk({"step_", nm}, 64'(cur), 64'(prev) + 64'd1);
        chk({"err_o_", nm}, 64'(err_o), 64'(e.erro));
      end
    end
  endtask

  // Monitor: every counter movement must match the next queued expectation.
  initial begin
    logic [CW-1:0] ph, pm, ps, pe;
    ph = '0; pm = '0; ps = '0; pe = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        ph = '0; pm = '0; ps = '0; pe = '0;
      end else begin
        mon_cnt("hit", hit_cnt_o, ph, HIT);
        mon_cnt("miss", miss_cnt_o, pm, MISS);
        mon_cnt("skip", skip_cnt_o, ps, SKIP);
        mon_cnt("err", err_cnt_o, pe, ERR);
        if (err_o && (err_cnt_o == pe)) begin
          checks++;
          failures++;
          $display("FAIL stray_err_o: actual=1 required=0");
        end
        ph = hit_cnt_o; pm = miss_cnt_o; ps = skip_cnt_o; pe = err_cnt_o;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [AW-1:0] a, input int id, input int len, input int size);
    ar_valid_i = 1; ar_ready_i = 1; ar_addr_i = a;
    ar_id_i = IW'(id); ar_len_i = 8'(len); ar_size_i = 3'(size);
    cyc();
    ar_valid_i = 0; ar_ready_i = 0;
  endtask

  task automatic rbeat(input int id, input logic [1:0] resp, input logic [DW-1:0] d, input logic last);
    r_valid_i = 1; r_ready_i = 1; r_id_i = IW'(id); r_resp_i = resp; r_data_i = d; r_last_i = last;
    cyc();
    r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
  endtask

  task automatic inval(input int p);
    inval_valid_i = 1; inval_page_i = 6'(p);
    cyc();
    inval_valid_i = 0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && expq.size() != 0; i++) cyc();
    cyc();
    chk({"drain_", nm}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    repeat (3) cyc();
    chk("rst_hit", 64'(hit_cnt_o), 0);
    chk("rst_err", 64'(err_cnt_o), 0);
    chk("rst_pv", 64'(page_valid_o), 0);
    chk("rst_outst", 64'(outst_o), 0);
    chk("rst_sticky", 64'(err_sticky_o), 0);
    rst_i = 0;
    cyc();

    init_all_i = 1; cyc(); init_all_i = 0;
    chk("init_pv", 64'(page_valid_o), {64{1'b1}});
    push(HIT, 0);
    ar(32'h1040, 0, 0, 2);
    rbeat(0, 2'b00, 32'hff001040, 1);
    drain("hit");
    chk("hit_cnt1", 64'(hit_cnt_o), 1);

    inval(3);
    chk("inval_pv", 64'(page_valid_o), ~(64'd1 << 3));
    push(MISS, 0);
    ar(32'h3000, 1, 0, 2);
    rbeat(1, 2'b10, 32'h0, 1);
    push(ERR, 1);
    ar(32'h3000, 1, 0, 2);
    rbeat(1, 2'b00, 32'hff003000, 1);
    drain("miss_err");
    chk("miss_cnt1", 64'(miss_cnt_o), 1);
    chk("err_cnt1", 64'(err_cnt_o), 1);

    inval(9);
    chk("pv9_clear", 64'(page_valid_o[9]), 0);
    inval_valid_i = 1; inval_page_i = 6'd9; ins_valid_i = 1; ins_page_i = 6'd9;
    cyc();
    inval_valid_i = 0; ins_valid_i = 0;
    chk("pv9_ins_wins", 64'(page_valid_o[9]), 1);

    push(SKIP, 0);
    ar(32'h5000, 2, 0, 2);
    inval(5);
    rbeat(2, 2'b10, 32'h0, 1);
    drain("dirty");
    chk("err_cnt_dirty", 64'(err_cnt_o), 1);

    for (int i = 0; i < 8; i++) ar(32'h8000 + 32'(i) * 32'h100, i % 4, 0, 2);
    chk("outst8", 64'(outst_o), 8);
    push(SKIP, 0);
    ar(32'h9000, 0, 0, 2);
    chk("overflow", 64'(overflow_o), 1);
    chk("outst_full", 64'(outst_o), 8);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        id = (j == 0) ? 3 : (j == 1) ? 1 : (j == 2) ? 0 : 2;
        push(HIT, 0);
        rbeat(id, 2'b00, 32'hff008000 + 32'(id + 4 * k) * 32'h100, 1);
      end
    end
    drain("multi");
    chk("hit_cnt9", 64'(hit_cnt_o), 9);
    chk("outst0", 64'(outst_o), 0);

    push(SKIP, 0);
    ar(32'h0ffc, 0, 1, 2);
    rbeat(0, 2'b00, 32'h0, 0);
    rbeat(0, 2'b00, 32'h0, 1);
    push(ERR, 1);
    ar(32'h2000, 1, 3, 2);
    rbeat(1, 2'b00, 32'hff002000, 0);
    rbeat(1, 2'b00, 32'hff002004, 0);
    rbeat(1, 2'b00, 32'hdeadbeef, 0);
    rbeat(1, 2'b00, 32'hff00200c, 1);
    drain("burst");
    chk("skip_cnt3", 64'(skip_cnt_o), 3);
    chk("err_cnt2", 64'(err_cnt_o), 2);

    ar(32'h4000, 0, 3, 2);
    rbeat(0, 2'b00, 32'hff004000, 0);
    rst_i = 1;
    #1;
    chk("mid_rst_hit", 64'(hit_cnt_o), 0);
    chk("mid_rst_skip", 64'(skip_cnt_o), 0);
    chk("mid_rst_err", 64'(err_cnt_o), 0);
    chk("mid_rst_pv", 64'(page_valid_o), 0);
    chk("mid_rst_outst", 64'(outst_o), 0);
    chk("mid_rst_ovf", 64'(overflow_o), 0);
    chk("mid_rst_sticky", 64'(err_sticky_o), 0);
    cyc();
    rst_i = 0;
    cyc();

    push(ERR, 1);
    rbeat(7, 2'b00, 32'h0, 1);
    drain("unexp");
    chk("unexp_sticky", 64'(err_sticky_o), 1);
    chk("unexp_err_cnt", 64'(err_cnt_o), 1);
    chk("unexp_outst", 64'(outst_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
